// File: rtl/calc_le_mult_pkg.sv
// rtl/calc_le_mult_pkg.sv - shared widths, tag-width helper and result type for the LE r-offset multiplier
package calc_le_mult_pkg;

  localparam int A_W_DEF = 18;
  localparam int B_W_DEF = 15;
  localparam int P_W_DEF = A_W_DEF + B_W_DEF;

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W_DEF = id_width(4);

  typedef struct packed {
    logic [ID_W_DEF-1:0]        id;
    logic signed [P_W_DEF-1:0]  p;
  } mult_res_t;

endpackage

// File: rtl/calc_le_mult_pipe.sv
// rtl/calc_le_mult_pipe.sv - two-stage signed multiplier (operands, then product) with tag and valid
module calc_le_mult_pipe #(
  parameter int A_W  = 18,
  parameter int B_W  = 15,
  parameter int ID_W = 2,
  parameter int P_W  = A_W + B_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   in_valid,
  input  logic [A_W-1:0]         in_a,
  input  logic [B_W-1:0]         in_b,
  input  logic [ID_W-1:0]        in_id,
  output logic                   v1,
  output logic                   out_valid,
  output logic [P_W-1:0]         out_p,
  output logic [ID_W-1:0]        out_id
);

  logic signed [A_W-1:0] a1;
  logic signed [B_W-1:0] b1;
  logic [ID_W-1:0]       id1;
  logic signed [P_W-1:0] p;

  // Plain registered operands feeding a registered product keeps this DSP-inferable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      id1       <= '0;
      out_valid <= 1'b0;
      p         <= '0;
      out_id    <= '0;
    end else if (ce) begin
      v1        <= in_valid;
      a1        <= in_a;
      b1        <= in_b;
      id1       <= in_id;
      out_valid <= v1;
      p         <= P_W'(a1) * P_W'(b1);
      out_id    <= id1;
    end
  end

  assign out_p = p;

endmodule

// File: rtl/calc_le_mult_arbiter.sv
// rtl/calc_le_mult_arbiter.sv - round-robin arbiter sharing one pipelined signed multiplier
module calc_le_mult_arbiter
  import calc_le_mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_W     = A_W_DEF,
  parameter int B_W     = B_W_DEF,
  parameter int P_W     = A_W + B_W,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [P_W-1:0]         res_p,
  output logic [ID_W-1:0]        res_id,
  output logic                   busy
);

  logic               ce;
  logic               found;
  logic               accept;
  logic               v1;
  logic               v2;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W-1:0]    idx;
  logic [A_W-1:0]     sel_a;
  logic [B_W-1:0]     sel_b;

  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        gnt_id      = idx;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        sel_a = req_a[i*A_W +: A_W];
        sel_b = req_b[i*B_W +: B_W];
      end
    end
  end

  // A result held against backpressure freezes every stage, including acceptance.
  assign ce        = !(v2 && !res_ready);
  assign accept    = found && ce;
  assign req_ready = grant & {NUM_REQ{ce && rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  calc_le_mult_pipe #(
    .A_W  (A_W),
    .B_W  (B_W),
    .ID_W (ID_W),
    .P_W  (P_W)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .in_valid  (accept),
    .in_a      (sel_a),
    .in_b      (sel_b),
    .in_id     (gnt_id),
    .v1        (v1),
    .out_valid (v2),
    .out_p     (res_p),
    .out_id    (res_id)
  );

  assign res_valid = v2;
  assign busy      = v1 | v2;

endmodule

// File: tb/tb_calc_le_mult_arbiter.sv
// tb/tb_calc_le_mult_arbiter.sv - scoreboard bench for the shared-multiplier arbiter
module tb_calc_le_mult_arbiter;
  import calc_le_mult_pkg::*;

  localparam int N  = 4;
  localparam int AW = 18;
  localparam int BW = 15;
  localparam int PW = 33;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic            res_valid;
  logic            res_ready;
  logic [PW-1:0]   res_p;
  logic [IW-1:0]   res_id;
  logic            busy;

  logic signed [AW-1:0] ta [N];
  logic signed [BW-1:0] tbv[N];
  logic                 tv [N];
  int                   cnt[N];

  mult_res_t sbq[$];
  int        dlog[$];
  int        mptr;
  logic      mv1, mv2, stall_prev;
  logic [PW-1:0] hold_p;
  logic [IW-1:0] hold_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = tv[i];
      req_a[i*AW +: AW]   = ta[i];
      req_b[i*BW +: BW]   = tbv[i];
    end
  end

  calc_le_mult_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_p     (res_p),
    .res_id    (res_id),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    mptr       = 0;
    mv1        = 1'b0;
    mv2        = 1'b0;
    stall_prev = 1'b0;
  endtask

  task automatic step();
    int        mg;
    logic      mce;
    logic [N-1:0] exp_ready;
    mult_res_t r;
    @(negedge clk);
    mce = !(mv2 && !res_ready);
    mg  = -1;
    for (int k = 0; k < N; k++)
      if (mg < 0 && tv[(mptr + k) % N]) mg = (mptr + k) % N;
    exp_ready = '0;
    if (mg >= 0 && mce) exp_ready[mg] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("res_valid", 64'(res_valid), 64'(mv2));
    check("busy", 64'(busy), 64'(mv1 | mv2));
    for (int i = 0; i < N; i++)
      if (req_ready[i] && req_valid[i]) dlog.push_back(i);
    if (stall_prev) begin
      check("stall_p", {31'b0, res_p}, {31'b0, hold_p});
      check("stall_id", 64'(res_id), 64'(hold_id));
    end
    stall_prev = res_valid && !res_ready;
    hold_p     = res_p;
    hold_id    = res_id;
    if (res_valid && res_ready) begin
      if (sbq.size() == 0) begin
        check("spurious_result", 64'(1), 64'(0));
      end else begin
        r = sbq.pop_front();
        check("res_p", {31'b0, res_p}, {31'b0, r.p});
        check("res_id", 64'(res_id), 64'(r.id));
      end
    end
    @(posedge clk);
    #1;
    if (mce) begin
      mv2 = mv1;
      mv1 = (mg >= 0);
      if (mg >= 0) begin
        r.id = IW'(mg);
        r.p  = PW'(longint'(ta[mg]) * longint'(tbv[mg]));
        sbq.push_back(r);
        mptr = (mg + 1) % N;
        cnt[mg]--;
        if (cnt[mg] > 0) begin
          ta[mg]  = AW'($urandom);
          tbv[mg] = BW'($urandom);
        end else begin
          tv[mg] = 1'b0;
        end
      end
    end
  endtask

  task automatic load(input int i, input int n);
    tv[i]  = 1'b1;
    cnt[i] = n;
    ta[i]  = AW'($urandom);
    tbv[i] = BW'($urandom);
  endtask

  initial begin
    res_ready = 1'b1;
    rst_n     = 1'b0;
    for (int i = 0; i < N; i++) begin
      tv[i]  = 1'b1;
      ta[i]  = '0;
      tbv[i] = '0;
      cnt[i] = 0;
    end
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_p", {31'b0, res_p}, 64'(0));
    check("rst_res_id", 64'(res_id), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) tv[i] = 1'b0;
    tv[0] = 1'b1; ta[0] = 18'sd3; tbv[0] = -15'sd5; cnt[0] = 1;
    repeat (4) step();

    // Round-robin with every requester streaming
    dlog.delete();
    for (int i = 0; i < N; i++) load(i, 4);
    repeat (20) step();
    check("rr_count", 64'(dlog.size()), 64'(16));
    for (int k = 1; k < 8 && k < dlog.size(); k++)
      check("rr_order", 64'(dlog[k]), 64'((dlog[k-1] + 1) % N));

    // Operand extremes
    tv[0] = 1'b1; ta[0] = -18'sd131072; tbv[0] = -15'sd16384; cnt[0] = 1;
    tv[1] = 1'b1; ta[1] =  18'sd131071; tbv[1] = -15'sd16384; cnt[1] = 1;
    repeat (5) step();

    // Backpressure mid-stream
    load(0, 3);
    load(2, 3);
    repeat (3) step();
    res_ready = 1'b0;
    repeat (3) step();
    res_ready = 1'b1;
    repeat (8) step();

    // Pointer fairness
    dlog.delete();
    load(2, 1);
    for (int k = 0; k < 10 && tv[2]; k++) step();
    check("fair_req2_done", 64'(tv[2]), 64'(0));
    load(1, 1);
    load(3, 1);
    repeat (6) step();
    check("fair_n", 64'(dlog.size()), 64'(3));
    if (dlog.size() >= 3) begin
      check("fair_0", 64'(dlog[0]), 64'(2));
      check("fair_1", 64'(dlog[1]), 64'(3));
      check("fair_2", 64'(dlog[2]), 64'(1));
    end

    // Asynchronous reset with two entries in flight
    load(0, 2);
    repeat (2) step();
    check("pre_arst_valid", 64'(res_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_res_valid", 64'(res_valid), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_res_p", {31'b0, res_p}, 64'(0));
    for (int i = 0; i < N; i++) begin
      tv[i]  = 1'b0;
      cnt[i] = 0;
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step();
    dlog.delete();
    load(1, 1);
    load(3, 1);
    repeat (6) step();
    check("post_rst_n", 64'(dlog.size()), 64'(2));
    if (dlog.size() >= 1) check("post_rst_first", 64'(dlog[0]), 64'(1));
    check("sb_drained", 64'(sbq.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_le_mult_arbiter.md
# calc_le_mult_arbiter

Round-robin arbiter that shares one pipelined signed 18x15 multiplier among `NUM_REQ` requesters in the LE r-offset calculation path. Each requester presents an operand pair with valid/ready. The block grants one request per cycle, drives the shared two-stage multiplier with a common clock enable, and returns each product tagged with the requester index. Downstream backpressure freezes the whole pipeline without losing data.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `A_W`, 18: signed operand A width
- `B_W`, 15: signed operand B width
- `P_W`, `A_W+B_W` (33): signed product width; must not be overridden
- `ID_W`, `max(1,$clog2(NUM_REQ))`: tag width

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  `NUM_REQ`  per-requester operand valid
- `req_ready`  out  `NUM_REQ`  per-requester accept; at most one bit high
- `req_a`  in  `NUM_REQ*A_W`  packed signed A operands; requester i in slice i
- `req_b`  in  `NUM_REQ*B_W`  packed signed B operands
- `res_valid`  out  1  product valid
- `res_ready`  in  1  downstream accept
- `res_p`  out  `P_W`  signed product `a*b`
- `res_id`  out  `ID_W`  index of the originating requester
- `busy`  out  1  any stage holds a valid entry

## Operation
- Global enable: `ce = !(res_valid && !res_ready)`. All pipeline registers, valid bits and id registers advance only when `ce=1`.
- Arbitration:
  - Priority pointer `ptr` names the requester searched first.
  - The grant goes to the first `req_valid[i]`, searching i = ptr, ptr+1, … modulo `NUM_REQ`.
  - `req_ready[i] = grant[i] && ce`.
  - On acceptance (`req_valid[i] && req_ready[i]`), `ptr` becomes `(i+1) mod NUM_REQ`. Otherwise `ptr` holds.
- Stage 1 on accept with `ce`: register the selected `a`, `b`, `id`, and `v1=1`. With `ce` and no accept: `v1=0`, data don't-care.
- Stage 2 with `ce`: `p <= signed(a1)*signed(b1)` at full `P_W`, no truncation or saturation. `id2<=id1`, `v2<=v1`.
- Outputs: `res_valid=v2`, `res_p=p`, `res_id=id2`. A result is consumed when `res_valid && res_ready`.
- `busy = v1 | v2`.
- Requesters must hold `req_a`/`req_b` stable while `req_valid` is high and unaccepted. `req_valid` may drop without acceptance and causes no error.
- Grant is combinational from `req_valid` and `ptr`. No combinational path from `res_ready` to `res_valid`. There is a path from `res_ready` to `req_ready` through `ce`.

## Timing
- Reset (`rst_n=0`, async assert, sync release):
  - `v1=v2=0` and `ptr=0`.
  - `a1`, `b1`, `p`, `id1`, `id2` all cleared to 0.
  - Therefore `res_valid=0`, `res_p=0`, `res_id=0`, `busy=0`, `req_ready=0`.
- Latency: a request accepted in cycle t shows `res_valid=1` in cycle t+2 (edge t captures operands, edge t+1 captures product).
- Throughput: one accept per cycle while `res_ready=1`.
- Stall: `res_valid=1` with `res_ready=0` freezes every stage, `req_ready=0`, and `res_p`/`res_id` stay stable. The first cycle after `res_ready` returns to 1 resumes flow at full rate.
- Bubble: when `res_valid=0`, `ce=1` regardless of `res_ready`, so empty slots never stall.
- Simultaneous consume and accept in one cycle is legal: both stages shift.
- All `req_valid` low: `ptr` holds and `v1` loads 0.
- Single requester asserting continuously gets every cycle. Pointer wrap from `NUM_REQ-1` goes to 0.
- Reset mid-operation discards in-flight entries with no partial outputs. The first post-reset grant starts search at requester 0.

## Structure
- Shared package `calc_le_mult_pkg`:
  - Defaults `A_W`, `B_W`, `P_W`.
  - Function computing `ID_W`.
  - Typedef for the tagged result {id, p}.
- Sub-module `calc_le_mult_pipe`: two-stage signed multiplier with `ce`, operands registered then product registered, DSP-inferable. It carries `ID_W`-wide tag and valid alongside the data.
- The top holds the arbiter, `ptr`, and `ce` logic.

## Test plan
- Reset: hold `rst_n=0` with `req_valid=4'b1111` → all outputs 0. Release, drive req0 `a=3`, `b=-5` → `req_ready=4'b0001` that cycle, and 2 cycles later `res_valid=1`, `res_p=-15`, `res_id=0`.
- Round-robin: all four valid continuously with `res_ready=1` → grants 0,1,2,3,0,… one per cycle, and `res_id` follows the same order with 2-cycle lag.
- Extremes: `a=-131072`, `b=-16384` → `res_p=2147483648` (33-bit positive). `a=131071`, `b=-16384` → `res_p=-2147467264`.
- Backpressure: stream 6 requests and drop `res_ready` for 3 cycles mid-stream → `res_p`/`res_id` stable, `req_ready=0` throughout, no result lost or duplicated, and order preserved.
- Pointer fairness: only req2 valid, then req1 and req3 valid together → req2 served, then req3, then req1.
- Async reset while 2 entries are in flight → `res_valid` drops immediately, and no stale result appears after release.
